// File: rtl/reimu_shot.sv
// -----------------------------------------------------------------------------
// reimu_shot
//   Player shot generator. Keeps a fixed pool of NSHOT upward-moving shots,
//   spawns new ones at the player position on fire requests (rate-limited by
//   a cooldown counter), retires shots that leave the top of the screen or are
//   hit, and publishes the pool to the renderer and collision stage.
//
// Ports
//   clk22       game tick clock, all state updates on its rising edge
//   rst         synchronous active-high reset, highest priority
//   gameover    clears the pool and cooldown while high
//   fire        fire request level (holding it gives autofire)
//   reimux/y    player position (10 bit each)
//   hit         per-slot kill request from the collision stage
//   shotx/y     slot i position at bits [10i+9:10i]
//   shotvalid   slot i active
//   shot_fired  one-tick pulse on every spawn
//   active_cnt  number of set bits in shotvalid
// -----------------------------------------------------------------------------
module reimu_shot #(
   parameter int         NSHOT    = 4,
   parameter logic [9:0] SPEED    = 10'd8,
   parameter logic [3:0] COOLDOWN = 4'd6,
   parameter logic [9:0] XOFS     = 10'd16,
   parameter logic [9:0] SHOT_H   = 10'd16
) (
   input  logic                 clk22,
   input  logic                 rst,
   input  logic                 gameover,
   input  logic                 fire,
   input  logic [9:0]           reimux,
   input  logic [9:0]           reimuy,
   input  logic [NSHOT-1:0]     hit,
   output logic [10*NSHOT-1:0]  shotx,
   output logic [10*NSHOT-1:0]  shoty,
   output logic [NSHOT-1:0]     shotvalid,
   output logic                 shot_fired,
   output logic [3:0]           active_cnt
);

   logic [NSHOT-1:0] valid_reg;
   logic [NSHOT-1:0] valid_next;
   logic [NSHOT-1:0] spawn_sel;
   logic             any_free;
   logic             parked;
   logic             spawn_ok;
   logic [9:0]       spawn_x;
   logic [9:0]       spawn_y;
   logic [3:0]       cool_reg;
   logic [3:0]       cool_next;
   logic [3:0]       cnt_next;

   // Lowest-index free slot, judged on the pool as registered at the start
   // of the tick, so a slot freed this tick cannot be reused until the next.
   always_comb begin
      spawn_sel = '0;
      any_free  = 1'b0;
      for (int i = 0; i < NSHOT; i++) begin
         if (!valid_reg[i] && !any_free) begin
            spawn_sel[i] = 1'b1;
            any_free     = 1'b1;
         end
      end
   end

   assign parked   = (reimux == 10'd0) && (reimuy == 10'd0);
   assign spawn_ok = fire && (cool_reg == 4'd0) && !parked && any_free;
   assign spawn_x  = reimux + XOFS;
   // Clamp at the top row instead of wrapping below zero.
   assign spawn_y  = (reimuy >= SHOT_H) ? (reimuy - SHOT_H) : 10'd0;

   // A blocked spawn (pool full) leaves the cooldown at zero so the shot
   // goes out on the first tick a slot is free.
   always_comb begin
      cool_next = cool_reg;
      if (spawn_ok) begin
         cool_next = COOLDOWN;
      end else if (cool_reg != 4'd0) begin
         cool_next = cool_reg - 4'd1;
      end
   end

   always_comb begin
      cnt_next = 4'd0;
      for (int i = 0; i < NSHOT; i++) begin
         cnt_next = cnt_next + {3'd0, valid_next[i]};
      end
   end

   generate
      for (genvar gi = 0; gi < NSHOT; gi++) begin : g_slot
         logic       v_reg;
         logic       v_next;
         logic [9:0] x_reg;
         logic [9:0] x_next;
         logic [9:0] y_reg;
         logic [9:0] y_next;

         always_comb begin
            v_next = v_reg;
            x_next = x_reg;
            y_next = y_reg;
            if (v_reg) begin
               if (hit[gi]) begin
                  v_next = 1'b0;
               end else if (y_reg < SPEED) begin
                  v_next = 1'b0;
               end else begin
                  y_next = y_reg - SPEED;
               end
            end else if (spawn_ok && spawn_sel[gi]) begin
               // Freshly spawned shot sits at its spawn row for this tick.
               v_next = 1'b1;
               x_next = spawn_x;
               y_next = spawn_y;
            end
         end

         always_ff @(posedge clk22) begin
            if (rst || gameover) begin
               v_reg <= 1'b0;
               x_reg <= 10'd0;
               y_reg <= 10'd0;
            end else begin
               v_reg <= v_next;
               x_reg <= x_next;
               y_reg <= y_next;
            end
         end

         assign valid_reg[gi]         = v_reg;
         assign valid_next[gi]        = v_next;
         assign shotx[10*gi +: 10]    = x_reg;
         assign shoty[10*gi +: 10]    = y_reg;
      end
   endgenerate

   always_ff @(posedge clk22) begin
      if (rst || gameover) begin
         cool_reg   <= 4'd0;
         shot_fired <= 1'b0;
         active_cnt <= 4'd0;
      end else begin
         cool_reg   <= cool_next;
         shot_fired <= spawn_ok;
         active_cnt <= cnt_next;
      end
   end

   assign shotvalid = valid_reg;

endmodule

// File: tb/tb_reimu_shot.sv
// -----------------------------------------------------------------------------
// tb_reimu_shot
//   Directed bench for reimu_shot. Each stimulus step pushes the hand-computed
//   state expected after the coming clk22 edge into a queue, tagged with that
//   edge number; a separate monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_reimu_shot;

   localparam int NSHOT = 4;

   logic                clk22;
   logic                rst;
   logic                gameover;
   logic                fire;
   logic [9:0]          reimux;
   logic [9:0]          reimuy;
   logic [NSHOT-1:0]    hit;
   logic [10*NSHOT-1:0] shotx;
   logic [10*NSHOT-1:0] shoty;
   logic [NSHOT-1:0]    shotvalid;
   logic                shot_fired;
   logic [3:0]          active_cnt;

   reimu_shot #(
      .NSHOT    (NSHOT),
      .SPEED    (10'd8),
      .COOLDOWN (4'd6),
      .XOFS     (10'd16),
      .SHOT_H   (10'd16)
   ) dut (
      .clk22      (clk22),
      .rst        (rst),
      .gameover   (gameover),
      .fire       (fire),
      .reimux     (reimux),
      .reimuy     (reimuy),
      .hit        (hit),
      .shotx      (shotx),
      .shoty      (shoty),
      .shotvalid  (shotvalid),
      .shot_fired (shot_fired),
      .active_cnt (active_cnt)
   );

   initial clk22 = 1'b0;
   always #5 clk22 = ~clk22;

   typedef struct {
      int         cyc;
      logic [3:0] v;
      logic [3:0] cnt;
      logic       f;
      int         slot;
      logic [9:0] x;
      logic [9:0] y;
   } exp_t;

   exp_t q[$];
   int   edge_cnt = 0;
   int   n_tests  = 0;
   int   n_fail   = 0;

   // Monitor: after every edge, compare any expectation tagged for that edge.
   always begin
      @(posedge clk22);
      edge_cnt++;
      #3;
      while (q.size() > 0 && q[0].cyc == edge_cnt) begin
         exp_t e;
         logic [9:0] gx;
         logic [9:0] gy;
         e  = q.pop_front();
         gx = shotx[10*e.slot +: 10];
         gy = shoty[10*e.slot +: 10];
         n_tests += 5;
         if (shotvalid !== e.v) begin
            n_fail++;
            $display("FAIL valid edge=%0d got=%b want=%b", e.cyc, shotvalid, e.v);
         end
         if (active_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL active_cnt edge=%0d got=%0d want=%0d", e.cyc, active_cnt, e.cnt);
         end
         if (shot_fired !== e.f) begin
            n_fail++;
            $display("FAIL shot_fired edge=%0d got=%b want=%b", e.cyc, shot_fired, e.f);
         end
         if (gx !== e.x) begin
            n_fail++;
            $display("FAIL shotx[%0d] edge=%0d got=%0d want=%0d", e.slot, e.cyc, gx, e.x);
         end
         if (gy !== e.y) begin
            n_fail++;
            $display("FAIL shoty[%0d] edge=%0d got=%0d want=%0d", e.slot, e.cyc, gy, e.y);
         end
      end
      if (q.size() > 0 && q[0].cyc < edge_cnt) begin
         n_tests++;
         n_fail++;
         $display("FAIL stale_expectation edge=%0d got=none want=checked", q[0].cyc);
         void'(q.pop_front());
      end
   end

   // Drive one tick of inputs and queue the state expected after its edge.
   task automatic step(input logic r, input logic g, input logic f,
                       input logic [9:0] px, input logic [9:0] py,
                       input logic [3:0] h, input logic [3:0] ev, input logic ef,
                       input int sl, input logic [9:0] ex, input logic [9:0] ey);
      exp_t e;
      rst      = r;
      gameover = g;
      fire     = f;
      reimux   = px;
      reimuy   = py;
      hit      = h;
      e.cyc  = edge_cnt + 1;
      e.v    = ev;
      e.cnt  = 4'($countones(ev));
      e.f    = ef;
      e.slot = sl;
      e.x    = ex;
      e.y    = ey;
      q.push_back(e);
      $display("[TB] edge %0d: rst=%b go=%b fire=%b pos=(%0d,%0d) hit=%b -> valid=%b fired=%b slot%0d=(%0d,%0d)",
               e.cyc, r, g, f, px, py, h, ev, ef, sl, ex, ey);
      @(posedge clk22);
      #1;
   endtask

   initial begin
      logic [3:0] v;
      logic       fd;

      // Reset wins over fire.
      step(1, 0, 1, 220, 360, 4'b0000, 4'b0000, 0, 0, 0, 0);

      // Single shot, then one move.
      step(0, 0, 1, 220, 360, 4'b0000, 4'b0001, 1, 0, 236, 344);
      step(0, 0, 0, 220, 360, 4'b0000, 4'b0001, 0, 0, 236, 336);
      step(0, 1, 1, 220, 360, 4'b0000, 4'b0000, 0, 0, 0, 0);

      // Autofire: spawns on ticks 0,7,14,21; pool full afterwards.
      for (int k = 0; k < 30; k++) begin
         fd = (k == 0) || (k == 7) || (k == 14) || (k == 21);
         v  = (k < 7) ? 4'b0001 : (k < 14) ? 4'b0011 : (k < 21) ? 4'b0111 : 4'b1111;
         step(0, 0, 1, 220, 360, 4'b0000, v, fd, 0, 236, 10'(344 - 8 * k));
      end
      // Hit frees slot0, but it is only reusable on the following tick.
      step(0, 0, 1, 220, 360, 4'b0001, 4'b1110, 0, 3, 236, 272);
      step(0, 0, 1, 220, 360, 4'b0000, 4'b1111, 1, 0, 236, 344);

      // Gameover clears everything including cooldown: immediate respawn.
      step(0, 1, 0, 220, 360, 4'b0000, 4'b0000, 0, 0, 0, 0);
      step(0, 0, 1, 220, 360, 4'b0000, 4'b0001, 1, 0, 236, 344);
      step(0, 1, 0, 220, 360, 4'b0000, 4'b0000, 0, 0, 0, 0);

      // Top retirement: y=5 retires without wrapping; slot reused later.
      step(0, 0, 1, 100, 21, 4'b0000, 4'b0001, 1, 0, 116, 5);
      step(0, 0, 1, 100, 21, 4'b0000, 4'b0000, 0, 0, 116, 5);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 1, 100, 21, 4'b0000, 4'b0000, 0, 0, 116, 5);
      end
      step(0, 0, 1, 100, 21, 4'b0000, 4'b0001, 1, 0, 116, 5);
      step(0, 0, 0, 100, 21, 4'b0000, 4'b0000, 0, 0, 116, 5);

      // y exactly SPEED moves to 0, then retires.
      step(0, 1, 0, 100, 21, 4'b0000, 4'b0000, 0, 0, 0, 0);
      step(0, 0, 1, 50, 24, 4'b0000, 4'b0001, 1, 0, 66, 8);
      step(0, 0, 0, 50, 24, 4'b0000, 4'b0001, 0, 0, 66, 0);
      step(0, 0, 0, 50, 24, 4'b0000, 4'b0000, 0, 0, 66, 0);

      // Hit on a valid slot clears it; hit on an empty slot is ignored.
      step(0, 1, 0, 220, 360, 4'b0000, 4'b0000, 0, 0, 0, 0);
      step(0, 0, 1, 220, 360, 4'b0000, 4'b0001, 1, 0, 236, 344);
      for (int k = 1; k < 7; k++) begin
         step(0, 0, 1, 220, 360, 4'b0000, 4'b0001, 0, 0, 236, 10'(344 - 8 * k));
      end
      step(0, 0, 1, 220, 360, 4'b0000, 4'b0011, 1, 1, 236, 344);
      step(0, 0, 0, 220, 360, 4'b0010, 4'b0001, 0, 1, 236, 344);
      step(0, 0, 0, 220, 360, 4'b1000, 4'b0001, 0, 0, 236, 272);

      // Parked player never fires; reimux=0 alone is not parked; y clamps to 0.
      step(0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
      end
      step(0, 0, 1, 0, 10, 4'b0000, 4'b0001, 1, 0, 16, 0);
      step(0, 0, 0, 0, 10, 4'b0000, 4'b0000, 0, 0, 16, 0);

      fire = 1'b0;
      for (int k = 0; k < 5 && q.size() > 0; k++) begin
         @(posedge clk22);
         #5;
      end
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain got=%0d_pending want=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reimu_shot.md
Name: reimu_shot

Overview:
- Player shot generator sitting directly downstream of the player-position stage.
- Consumes the player's reimux/reimuy and a fire request, and maintains a fixed pool of upward-moving shots.
- Publishes shot positions and valid flags to the VGA renderer and the enemy collision stage.
- Advances once per game tick (clk22 edge).

Parameters:
NSHOT, 4, number of shot slots in the pool (1..8)
SPEED, 10'd8, pixels a shot moves up per tick
COOLDOWN, 4'd6, ticks between successive spawns
XOFS, 10'd16, x offset from reimux to shot spawn column
SHOT_H, 10'd16, y offset above reimuy for spawn row

Ports:
clk22  input  1  game tick clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
gameover  input  1  game-over flag; clears the pool while high
fire  input  1  fire request level (held = autofire)
reimux  input  10  player x position
reimuy  input  10  player y position
hit  input  NSHOT  per-slot kill request from collision stage
shotx  output  10*NSHOT  slot i x at bits [10i+9:10i]
shoty  output  10*NSHOT  slot i y at bits [10i+9:10i]
shotvalid  output  NSHOT  slot i active
shot_fired  output  1  one-tick pulse on every spawn (sound trigger)
active_cnt  output  4  number of set bits in shotvalid

Behaviour:
- Reset (rst high at edge):
  - shotx, shoty, shotvalid, shot_fired, active_cnt all 0.
  - Internal cooldown counter 0.
  - rst has priority over everything.
- gameover high (rst low): same clearing as reset, no spawn, shot_fired 0; the pool stays empty while gameover is held.
- Per tick otherwise, for each slot i, using shotvalid as registered at the start of the tick:
  - Valid and hit[i]=1: slot cleared (valid 0); x/y hold last value.
  - Valid, no hit, shoty < SPEED: slot cleared (leaves top of screen; no 10-bit underflow wrap).
  - Valid, no hit, shoty >= SPEED: shoty <= shoty - SPEED; shotx unchanged.
  - Invalid: holds, except when chosen for spawn.
  - hit on an invalid slot is ignored.
- Spawn condition: fire=1, cooldown==0, not parked, and at least one slot invalid at start of tick.
  - Parked = reimux==0 and reimuy==0 (player held at origin).
- Spawn action:
  - Lowest-index invalid slot gets valid 1.
  - shotx = reimux + XOFS (10-bit; max 440+16, no overflow).
  - shoty = reimuy - SHOT_H if reimuy >= SHOT_H, else 0.
  - The spawned shot does not move in its spawn tick.
  - cooldown <= COOLDOWN; shot_fired = 1 for that tick only.
- A slot freed by retirement or hit in tick T is not reusable until tick T+1.
- If fire=1 and cooldown==0 but the pool is full: no spawn, cooldown stays 0, shot_fired 0; a spawn occurs on the first tick a slot is free.
- Cooldown:
  - Decrements by 1 each tick while nonzero, independent of fire.
  - Spawn ticks load COOLDOWN instead.
  - Resulting spawn spacing is COOLDOWN+1 ticks under held fire.
- active_cnt is registered and reflects shotvalid after the same edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Single shot: rst, then reimux=220, reimuy=360, fire pulse 1 tick → slot0 valid, x=236, y=344, shot_fired=1; next tick y=336, shot_fired=0.
- Autofire spacing: fire held, player at (220,360) → spawns on ticks 0,7,14,21 into slots 0..3; the 5th spawn waits until a slot frees, with no shot_fired meanwhile.
- Top retirement: shot at y=5 with SPEED=8 → next tick valid=0 (no wrap to 1021); active_cnt decrements; the slot is reused on the following spawn.
- Hit and ignore: hit=4'b0010 with slots 0,1 valid → slot1 cleared and slot0 moves; hit=4'b1000 on an empty slot3 → no effect.
- Gameover mid-flight: 3 active shots, gameover=1 for 1 tick → all valid 0, active_cnt 0, cooldown 0; fire on the next tick with gameover=0 spawns immediately.
- Edge spawn: reimuy=10 → spawned y=0; player at (0,0) with fire held → no spawn.
